fetch_ifid: RTL and testbench



---
 rtl/fetch_ifid_pkg.sv | 21 ++
 rtl/fetch_ifid_ifid_reg.sv | 47 ++++
 rtl/fetch_ifid.sv | 97 +++++++++
 tb/tb_fetch_ifid.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/fetch_ifid_pkg.sv
// fetch_ifid_pkg: constants and types shared by the fetch stage and the
// pipeline registers of the LEGv8 core.
//   N_DEF       default datapath / PC width
//   CNT_W_DEF   default retired-fetch counter width
//   NOP_INSTR   bubble instruction (decodes to all-zero controls)
//   RESET_PC    PC value loaded on reset
//   fetch_state_t  fetch FSM states {RUN, FAULT}
package fetch_ifid_pkg;

    localparam int unsigned N_DEF     = 64;
    localparam int unsigned CNT_W_DEF = 32;

    localparam logic [31:0] NOP_INSTR = '0;
    localparam logic [63:0] RESET_PC  = '0;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_t;

endpackage : fetch_ifid_pkg

// File: rtl/fetch_ifid_ifid_reg.sv
// ifid_reg: IF/ID pipeline register with load enable and synchronous flush.
// Reset and flush both load a bubble {pc=0, instr=NOP, valid=0}; flush
// overrides the enable so a redirect always squashes even under stall.
//   clk      rising-edge clock
//   i_reset  synchronous active-high reset
//   i_en     load enable (deasserted while stalled)
//   i_flush  load a bubble
//   i_pc / i_instr / i_valid   next contents
//   o_pc / o_instr / o_valid   registered contents
module ifid_reg
    import fetch_ifid_pkg::*;
#(
    parameter int unsigned N = N_DEF
) (
    input  logic         clk,
    input  logic         i_reset,
    input  logic         i_en,
    input  logic         i_flush,
    input  logic [N-1:0] i_pc,
    input  logic [31:0]  i_instr,
    input  logic         i_valid,
    output logic [N-1:0] o_pc,
    output logic [31:0]  o_instr,
    output logic         o_valid
);

    logic [N-1:0] r_pc;
    logic [31:0]  r_instr;
    logic         r_valid;

    always_ff @(posedge clk) begin
        if (i_reset || i_flush) begin
            r_pc    <= '0;
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end else if (i_en) begin
            r_pc    <= i_pc;
            r_instr <= i_instr;
            r_valid <= i_valid;
        end
    end

    assign o_pc    = r_pc;
    assign o_instr = r_instr;
    assign o_valid = r_valid;

endmodule : ifid_reg

// File: rtl/fetch_ifid.sv
// fetch_ifid: instruction-fetch stage plus IF/ID register.
// Holds the PC (drives imem_addr), latches {PC, imem_data} into IF/ID,
// handles stall, branch redirect with IF/ID flush, and a sticky fault on a
// misaligned redirect target. Counts instructions latched valid.
//   clk, reset         clock, synchronous active-high reset
//   stall_F            hold PC and IF/ID
//   PCSrc, PCBranch    redirect request and target
//   imem_addr          instruction address (= PC register)
//   imem_data          combinational instruction read
//   IF_ID_pc/_instr/_valid  IF/ID contents
//   fault              misaligned redirect seen (sticky until reset)
//   fetch_count        instructions latched valid into IF/ID (wraps)
module fetch_ifid
    import fetch_ifid_pkg::*;
#(
    parameter int unsigned N     = N_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_F,
    input  logic             PCSrc,
    input  logic [N-1:0]     PCBranch,
    output logic [N-1:0]     imem_addr,
    input  logic [31:0]      imem_data,
    output logic [N-1:0]     IF_ID_pc,
    output logic [31:0]      IF_ID_instr,
    output logic             IF_ID_valid,
    output logic             fault,
    output logic [CNT_W-1:0] fetch_count
);

    fetch_state_t     r_state;
    logic [N-1:0]     r_pc;
    logic             r_fault;
    logic [CNT_W-1:0] r_fetch_count;

    logic [N-1:0]     w_pc_plus4;
    logic             w_misaligned;
    logic             w_flush;
    logic             w_en;

    assign w_pc_plus4   = r_pc + N'(4);
    assign w_misaligned = (PCBranch[1:0] != 2'b00);
    // Any redirect (aligned or not) squashes IF/ID; FAULT keeps it squashed.
    assign w_flush      = (r_state == FAULT) || PCSrc;
    assign w_en         = !stall_F;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= RUN;
            r_pc          <= N'(RESET_PC);
            r_fault       <= 1'b0;
            r_fetch_count <= '0;
        end else begin
            case (r_state)
                RUN: begin
                    if (PCSrc) begin
                        if (w_misaligned) begin
                            r_state <= FAULT;
                            r_fault <= 1'b1;
                        end else begin
                            r_pc <= PCBranch;
                        end
                    end else if (!stall_F) begin
                        r_pc          <= w_pc_plus4;
                        r_fetch_count <= r_fetch_count + CNT_W'(1);
                    end
                end
                FAULT: begin
                    r_state <= FAULT;
                end
                default: r_state <= RUN;
            endcase
        end
    end

    ifid_reg #(
        .N (N)
    ) u_ifid_reg (
        .clk     (clk),
        .i_reset (reset),
        .i_en    (w_en),
        .i_flush (w_flush),
        .i_pc    (r_pc),
        .i_instr (imem_data),
        .i_valid (1'b1),
        .o_pc    (IF_ID_pc),
        .o_instr (IF_ID_instr),
        .o_valid (IF_ID_valid)
    );

    assign imem_addr   = r_pc;
    assign fault       = r_fault;
    assign fetch_count = r_fetch_count;

endmodule : fetch_ifid

// File: tb/tb_fetch_ifid.sv
// Directed bench for fetch_ifid with a scoreboard of expected IF/ID entries.
module tb_fetch_ifid;

    localparam int unsigned N     = 64;
    localparam int unsigned CNT_W = 4;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        valid;
    } ifid_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             stall_F;
    logic             PCSrc;
    logic [N-1:0]     PCBranch;
    logic [N-1:0]     imem_addr;
    logic [31:0]      imem_data;
    logic [N-1:0]     IF_ID_pc;
    logic [31:0]      IF_ID_instr;
    logic             IF_ID_valid;
    logic             fault;
    logic [CNT_W-1:0] fetch_count;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    ifid_t       sb[$];
    logic [63:0] m_pc;
    logic        m_fault;
    logic [CNT_W-1:0] m_cnt;
    ifid_t       m_if;

    fetch_ifid #(
        .N     (N),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall_F     (stall_F),
        .PCSrc       (PCSrc),
        .PCBranch    (PCBranch),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .IF_ID_pc    (IF_ID_pc),
        .IF_ID_instr (IF_ID_instr),
        .IF_ID_valid (IF_ID_valid),
        .fault       (fault),
        .fetch_count (fetch_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] imem_word(input logic [63:0] a);
        if (a == 64'h0) return 32'hF84000A1;
        return 32'h8B000000 ^ a[31:0] ^ {a[63:48], 16'h0};
    endfunction

    always_comb imem_data = imem_word(imem_addr);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, predict the outcome, push it, then compare.
    task automatic step(input logic rst, input logic st, input logic ps, input logic [63:0] pb);
        ifid_t exp;
        ifid_t got;
        reset    = rst;
        stall_F  = st;
        PCSrc    = ps;
        PCBranch = pb;
        if (rst) begin
            m_pc = '0; m_fault = 1'b0; m_cnt = '0;
            exp = '{pc: 64'h0, instr: 32'h0, valid: 1'b0};
        end else if (m_fault) begin
            exp = '{pc: 64'h0, instr: 32'h0, valid: 1'b0};
        end else if (ps) begin
            if (pb[1:0] == 2'b00) m_pc = pb;
            else m_fault = 1'b1;
            exp = '{pc: 64'h0, instr: 32'h0, valid: 1'b0};
        end else if (st) begin
            exp = m_if;
        end else begin
            exp = '{pc: m_pc, instr: imem_word(m_pc), valid: 1'b1};
            m_pc  = m_pc + 64'd4;
            m_cnt = m_cnt + 1'b1;
        end
        m_if = exp;
        sb.push_back(exp);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        check("if_id_pc",    IF_ID_pc,             got.pc);
        check("if_id_instr", {32'h0, IF_ID_instr}, {32'h0, got.instr});
        check("if_id_valid", {63'h0, IF_ID_valid}, {63'h0, got.valid});
        check("imem_addr",   imem_addr,            m_pc);
        check("fault",       {63'h0, fault},       {63'h0, m_fault});
        check("fetch_count", {60'h0, fetch_count}, {60'h0, m_cnt});
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        m_pc = '0; m_fault = 1'b0; m_cnt = '0;
        m_if = '{pc: 64'h0, instr: 32'h0, valid: 1'b0};
        reset = 1'b1; stall_F = 1'b0; PCSrc = 1'b0; PCBranch = '0;
        @(posedge clk); #1;

        // Reset and free run from PC 0.
        step(1, 0, 0, 64'h0);
        repeat (4) step(0, 0, 0, 64'h0);

        // Stall for three cycles, then release.
        repeat (3) step(0, 1, 0, 64'h0);
        repeat (2) step(0, 0, 0, 64'h0);

        // Aligned redirect, bubble, then target.
        step(0, 0, 1, 64'h40);
        repeat (2) step(0, 0, 0, 64'h0);

        // Redirect and stall together: redirect wins.
        step(0, 1, 1, 64'h80);
        repeat (2) step(0, 0, 0, 64'h0);

        // PC wrap modulo 2^64.
        step(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC);
        repeat (3) step(0, 0, 0, 64'h0);

        // Enough fetches to wrap the narrow counter.
        repeat (10) step(0, 0, 0, 64'h0);

        // Reset in the middle of a stall.
        step(0, 1, 0, 64'h0);
        step(1, 1, 0, 64'h0);
        repeat (3) step(0, 0, 0, 64'h0);

        // Misaligned redirect: fault is sticky and inputs are ignored.
        step(0, 0, 1, 64'h42);
        step(0, 0, 0, 64'h0);
        step(0, 1, 0, 64'h0);
        step(0, 0, 1, 64'h100);
        step(0, 0, 0, 64'h0);

        // Reset clears the fault; fetch resumes from 0.
        step(1, 0, 0, 64'h0);
        repeat (2) step(0, 0, 0, 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_fetch_ifid
